hwag_ign_channel: RTL and testbench
===================================

# hwag_ign_channel

One ignition/injection output channel driven by the angle generator's 24-bit angle counter (0..3839 per crank revolution, 64 ticks per tooth). It extends crank angle to a 720° engine-cycle angle (0..7679) using a cam-seeded phase bit. It asserts its output between programmable set and reset angles. Set/reset angles are double-buffered and swap atomically at cycle wrap. A clock-based maximum-dwell guard forces the output off. Instances sit directly downstream of the angle generator core, one per coil or injector.

## Interface
- ANGLE_W, 24, width of incoming angle counter
- CYC_W, 13, width of engine-cycle angle (7680 < 8192)
- DWELL_W, 24, width of max-dwell timeout counter (clk cycles)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- hwag_start  in  1  angle generator synchronised
- acnt  in  ANGLE_W  crank angle, 0..3839
- cam_phase  in  1  phase seed, sampled on hwag_start rise (1 = second revolution)
- wr_en  in  1  write strobe for shadow angles and max_dwell
- wr_set  in  CYC_W  set (output-on) angle, 0..7679
- wr_reset  in  CYC_W  reset (output-off) angle, 0..7679
- wr_max_dwell  in  DWELL_W  dwell limit in clk cycles; 0 disables the guard
- out  out  1  channel output
- cyc_angle  out  CYC_W  current engine-cycle angle
- pending  out  1  shadow written, not yet applied
- dwell_tmo  out  1  sticky timeout flag; cleared by wr_en

## Operation
- Angle event: `acnt_q` is the registered `acnt`. An event occurs when `hwag_start & (acnt != acnt_q)`. Non-event cycles do nothing.
- Phase: on the hwag_start rising edge, phase <= cam_phase. On an event where acnt_q==3839 and acnt==0, phase toggles.
- `cyc_angle = phase ? acnt_q + 3840 : acnt_q`. Arithmetic uses CYC_W bits. An acnt value above 3839 is clamped to 3839.
- Cycle wrap: `cyc_angle` transitions from any nonzero value to 0.
- Shadow: wr_en loads shadow set/reset/max_dwell and sets pending.
  - Shadow is copied to the active registers when state is OFF, or on a cycle wrap. Either copy clears pending.
  - A wr_en coinciding with a wrap is stored in shadow. It is applied at the next wrap.
- FSM states: OFF, ARMED, ON, LOCKOUT.
  - OFF: out=0. Goes to ARMED one cycle after hwag_start=1.
  - ARMED: on an event with cyc_angle==set and set!=reset, go to ON.
  - ON: on an event with cyc_angle==reset, go to ARMED. On dwell counter reaching a nonzero max_dwell, go to LOCKOUT and set dwell_tmo.
  - LOCKOUT: out=0. Goes to ARMED on the next cycle wrap.
  - Any state goes to OFF when hwag_start=0.
- Dwell counter: clears on entry to ON and increments each clk while in ON. It saturates at all-ones.
- Angle jumps: comparison is equality on event values only. A resync jump that skips the set angle does not turn the output on that cycle. A jump that skips the reset angle leaves the output on until the dwell guard or hwag_start loss.

## Timing
- Reset: out=0, state OFF, phase=0, active and shadow angles 0, max_dwell 0, pending 0, dwell_tmo 0, cyc_angle 0, acnt_q 0.
- Latency: out changes 2 clk after acnt presents the matching value: one cycle for acnt_q, one for the registered out.
- A shadow copy at a wrap takes effect for comparisons on the following event. Angle 0 of the new cycle is compared against the old active values.
- Simultaneous events:
  - set==reset: never turns on.
  - Reset match and timeout in the same cycle: go to ARMED; dwell_tmo is not set.
  - hwag_start=0 has priority over all other conditions.
  - wr_en and a timeout in the same cycle: dwell_tmo ends 1 (set has priority).
- Mid-pulse loss of sync: out=0 on the next clk and pending shadow is applied; the pulse is not resumed after resync.

## Structure
- Shared package `hwag_pkg`:
  - ANG_PER_REV=3840, ANG_PER_CYCLE=7680, CYC_W=13
  - `ign_state_t` enum {OFF, ARMED, ON, LOCKOUT}
- Sub-module `hwag_cycle_angle`: acnt_q register, event detect, phase tracking, clamp, cyc_angle and wrap outputs. It is reusable by every channel instance; one instance may feed several channels.

## Test plan
- Cam seed and phase: hwag_start rises with cam_phase=1 and acnt=100 -> cyc_angle=3940. Step acnt 3839->0 -> cyc_angle steps 7679->0 and phase=0.
- Normal pulse: set=1000, reset=1128, max_dwell=0, ramp acnt from 0 -> out rises 2 clk after acnt=1000 and falls 2 clk after acnt=1128. Repeats each 7680 ticks.
- Double buffer: in ON at angle 1050, write set=2000/reset=2100 -> current pulse still ends at 1128; pending=1 until the wrap. The next cycle pulses at 2000..2100.
- Dwell guard: set=1000, reset=1128, max_dwell=50, one acnt step per 10 clk -> out falls 50 clk after rising and dwell_tmo=1. The output stays low until the wrap and re-arms for the next cycle.
- Sync loss: drop hwag_start while out=1 -> out=0 next clk and state OFF. Re-raise with cam_phase=0 -> no output until acnt reaches set again.
- Skip and edge cases: set=reset=500 -> out never rises. Jump acnt 990->1010 across set=1000 -> out stays 0 for that cycle.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared constants and types for the angle-generator output channels.
// Crank angle runs 0..3839 per revolution; the engine cycle spans two revolutions.
package hwag_pkg;

    localparam int ANGLE_W       = 24;
    localparam int CYC_W         = 13;
    localparam int DWELL_W       = 24;
    localparam int ANG_PER_REV   = 3840;
    localparam int ANG_PER_CYCLE = 7680;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ARMED   = 2'd1,
        ON      = 2'd2,
        LOCKOUT = 2'd3
    } ign_state_t;

endpackage

// File: rtl/hwag_ign_channel_if.sv
// Configuration and status bus of one ignition/injection channel.
interface hwag_ign_channel_if #(
    parameter int CYC_W   = 13,
    parameter int DWELL_W = 24
);
    // wr_en is a single-cycle write strobe with no back-pressure: every cycle it is
    // high, wr_set/wr_reset/wr_max_dwell are captured into the shadow registers.
    logic               wr_en;
    logic [CYC_W-1:0]   wr_set;
    logic [CYC_W-1:0]   wr_reset;
    logic [DWELL_W-1:0] wr_max_dwell;
    logic               pending;
    logic               dwell_tmo;

    modport master (
        output wr_en, wr_set, wr_reset, wr_max_dwell,
        input  pending, dwell_tmo
    );

    modport slave (
        input  wr_en, wr_set, wr_reset, wr_max_dwell,
        output pending, dwell_tmo
    );

endinterface

// File: rtl/hwag_cycle_angle.sv
// Extends the crank angle counter to a 720-degree engine-cycle angle and flags
// angle events and cycle wraps; one instance can feed several channels.
module hwag_cycle_angle #(
    parameter int ANGLE_W = 24,
    parameter int CYC_W   = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hwag_start,
    input  logic [ANGLE_W-1:0] acnt,
    input  logic               cam_phase,
    output logic [CYC_W-1:0]   cyc_angle,
    output logic               ang_evt,
    output logic               cyc_wrap
);
    import hwag_pkg::*;

    localparam int REV_MAX = ANG_PER_REV - 1;

    logic [CYC_W-1:0] acnt_c;
    logic [CYC_W-1:0] acnt_q, acnt_d;
    logic [CYC_W-1:0] cyc_prev_q, cyc_prev_d;
    logic             start_q, start_d;
    logic             phase_q, phase_d;
    logic             evt_q, evt_d;
    logic             evt_now;

    always_comb begin
        acnt_c  = (acnt > ANGLE_W'(REV_MAX)) ? CYC_W'(REV_MAX) : acnt[CYC_W-1:0];
        evt_now = hwag_start && (acnt_c != acnt_q);

        phase_d = phase_q;
        if (hwag_start && !start_q) begin
            phase_d = cam_phase;
        end else if (evt_now && (acnt_q == CYC_W'(REV_MAX)) && (acnt_c == '0)) begin
            phase_d = ~phase_q;
        end

        acnt_d     = acnt_c;
        start_d    = hwag_start;
        // The event flag is delayed so it lines up with the angle it produced.
        evt_d      = evt_now;
        cyc_prev_d = cyc_angle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acnt_q     <= '0;
            cyc_prev_q <= '0;
            start_q    <= 1'b0;
            phase_q    <= 1'b0;
            evt_q      <= 1'b0;
        end else begin
            acnt_q     <= acnt_d;
            cyc_prev_q <= cyc_prev_d;
            start_q    <= start_d;
            phase_q    <= phase_d;
            evt_q      <= evt_d;
        end
    end

    assign cyc_angle = phase_q ? (acnt_q + CYC_W'(ANG_PER_REV)) : acnt_q;
    assign ang_evt   = evt_q;
    assign cyc_wrap  = (cyc_angle == '0) && (cyc_prev_q != '0);

endmodule

// File: rtl/hwag_ign_channel.sv
// One ignition/injection output: on between double-buffered set/reset angles,
// with a clock-based maximum-dwell guard that locks the output off until the next cycle.
module hwag_ign_channel #(
    parameter int ANGLE_W = 24,
    parameter int CYC_W   = 13,
    parameter int DWELL_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hwag_start,
    input  logic [ANGLE_W-1:0]   acnt,
    input  logic                 cam_phase,
    hwag_ign_channel_if.slave    cfg,
    output logic                 out,
    output logic [CYC_W-1:0]     cyc_angle,
    output hwag_pkg::ign_state_t state
);
    import hwag_pkg::*;

    ign_state_t         state_q, state_d;
    logic [CYC_W-1:0]   set_q, set_d, reset_q, reset_d;
    logic [CYC_W-1:0]   sh_set_q, sh_set_d, sh_reset_q, sh_reset_d;
    logic [DWELL_W-1:0] maxd_q, maxd_d, sh_maxd_q, sh_maxd_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
    logic               pending_q, pending_d;
    logic               tmo_q, tmo_d;
    logic               ang_evt, cyc_wrap;
    logic               set_hit, reset_hit, dwell_hit, tmo_fire, apply;

    hwag_cycle_angle #(.ANGLE_W(ANGLE_W), .CYC_W(CYC_W)) u_cycle_angle (
        .clk        (clk),
        .rst        (rst),
        .hwag_start (hwag_start),
        .acnt       (acnt),
        .cam_phase  (cam_phase),
        .cyc_angle  (cyc_angle),
        .ang_evt    (ang_evt),
        .cyc_wrap   (cyc_wrap)
    );

    // dwell_inc counts the current ON cycle too, so the pulse lasts exactly max_dwell clocks.
    always_comb begin
        dwell_inc = (dwell_q == {DWELL_W{1'b1}}) ? dwell_q : dwell_q + 1'b1;
        dwell_hit = (maxd_q != '0) && (dwell_inc >= maxd_q);
        set_hit   = ang_evt && (cyc_angle == set_q) && (set_q != reset_q);
        reset_hit = ang_evt && (cyc_angle == reset_q);
        tmo_fire  = hwag_start && (state_q == ON) && !reset_hit && dwell_hit;
    end

    always_comb begin
        state_d = state_q;
        if (!hwag_start) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF:     state_d = ARMED;
                ARMED:   if (set_hit) state_d = ON;
                ON: begin
                    if (reset_hit)      state_d = ARMED;
                    else if (dwell_hit) state_d = LOCKOUT;
                end
                LOCKOUT: if (cyc_wrap) state_d = ARMED;
                default: state_d = OFF;
            endcase
        end
    end

    always_comb begin
        out   = (state_q == ON);
        state = state_q;
    end

    // A write landing on a wrap stays in shadow; the copy takes the older shadow value.
    always_comb begin
        apply      = (state_q == OFF) || cyc_wrap;
        set_d      = apply ? sh_set_q   : set_q;
        reset_d    = apply ? sh_reset_q : reset_q;
        maxd_d     = apply ? sh_maxd_q  : maxd_q;
        sh_set_d   = cfg.wr_en ? cfg.wr_set       : sh_set_q;
        sh_reset_d = cfg.wr_en ? cfg.wr_reset     : sh_reset_q;
        sh_maxd_d  = cfg.wr_en ? cfg.wr_max_dwell : sh_maxd_q;
        pending_d  = cfg.wr_en ? 1'b1 : (apply ? 1'b0 : pending_q);
        tmo_d      = tmo_fire  ? 1'b1 : (cfg.wr_en ? 1'b0 : tmo_q);
        dwell_d    = (state_q == ON) ? dwell_inc : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            set_q      <= '0;
            reset_q    <= '0;
            maxd_q     <= '0;
            sh_set_q   <= '0;
            sh_reset_q <= '0;
            sh_maxd_q  <= '0;
            dwell_q    <= '0;
            pending_q  <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            reset_q    <= reset_d;
            maxd_q     <= maxd_d;
            sh_set_q   <= sh_set_d;
            sh_reset_q <= sh_reset_d;
            sh_maxd_q  <= sh_maxd_d;
            dwell_q    <= dwell_d;
            pending_q  <= pending_d;
            tmo_q      <= tmo_d;
        end
    end

    assign cfg.pending   = pending_q;
    assign cfg.dwell_tmo = tmo_q;

endmodule

// File: tb/tb_hwag_ign_channel.sv
// Bench for hwag_ign_channel: directed scenarios plus random angle walks, all
// scored against an engine-level reference model.
module tb_hwag_ign_channel;
    import hwag_pkg::*;

    localparam int SB_W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  hwag_start;
    logic [23:0]           acnt;
    logic                  cam_phase;
    logic                  out;
    logic [12:0]           cyc_angle;
    ign_state_t            state;

    hwag_ign_channel_if #(.CYC_W(13), .DWELL_W(24)) bus ();

    hwag_ign_channel dut (
        .clk        (clk),
        .rst        (rst),
        .hwag_start (hwag_start),
        .acnt       (acnt),
        .cam_phase  (cam_phase),
        .cfg        (bus.slave),
        .out        (out),
        .cyc_angle  (cyc_angle),
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [SB_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (engine-level view) ----------------
    localparam int M_OFF = 0, M_ARMED = 1, M_ON = 2, M_LOCK = 3;
    int m_acnt, m_angle, m_mode, m_on_time;
    int m_set, m_reset, m_maxd, m_sh_set, m_sh_reset, m_sh_maxd;
    bit m_start_prev, m_phase, m_fresh, m_wrap, m_pending, m_tmo;

    task automatic model_reset();
        m_acnt = 0; m_angle = 0; m_mode = M_OFF; m_on_time = 0;
        m_set = 0; m_reset = 0; m_maxd = 0; m_sh_set = 0; m_sh_reset = 0; m_sh_maxd = 0;
        m_start_prev = 0; m_phase = 0; m_fresh = 0; m_wrap = 0; m_pending = 0; m_tmo = 0;
    endtask

    task automatic model_step(input bit start, input int a_raw, input bit cam,
                              input bit we, input int ws, input int wrr, input int wm);
        int a, nxt, new_angle;
        bit copy, fire, event_now;
        a    = (a_raw > ANG_PER_REV - 1) ? ANG_PER_REV - 1 : a_raw;
        copy = (m_mode == M_OFF) || m_wrap;
        fire = 0;
        nxt  = m_mode;
        if (!start) nxt = M_OFF;
        else begin
            case (m_mode)
                M_OFF:   nxt = M_ARMED;
                M_ARMED: if (m_fresh && m_angle == m_set && m_set != m_reset) nxt = M_ON;
                M_ON: begin
                    m_on_time++;
                    if (m_fresh && m_angle == m_reset) nxt = M_ARMED;
                    else if (m_maxd != 0 && m_on_time >= m_maxd) begin
                        nxt = M_LOCK;
                        fire = 1;
                    end
                end
                default: if (m_wrap) nxt = M_ARMED;
            endcase
        end
        if (nxt == M_ON && m_mode != M_ON) m_on_time = 0;
        m_mode = nxt;
        if (fire) m_tmo = 1;
        else if (we) m_tmo = 0;
        if (copy) begin
            m_set = m_sh_set; m_reset = m_sh_reset; m_maxd = m_sh_maxd;
        end
        if (we) begin
            m_sh_set = ws; m_sh_reset = wrr; m_sh_maxd = wm; m_pending = 1;
        end else if (copy) m_pending = 0;
        // angle tracking
        event_now = start && (a != m_acnt);
        if (start && !m_start_prev) m_phase = cam;
        else if (event_now && m_acnt == ANG_PER_REV - 1 && a == 0) m_phase = !m_phase;
        m_start_prev = start;
        m_acnt       = a;
        m_fresh      = event_now;
        new_angle    = m_acnt + (m_phase ? ANG_PER_REV : 0);
        m_wrap       = (new_angle == 0) && (m_angle != 0);
        m_angle      = new_angle;
    endtask

    // ---------------- drivers ----------------
    bit st = 0;
    bit cam = 0;
    int cur_a = 0;
    int rise_a, fall_a;

    task automatic step(input bit start, input int a, input bit c,
                        input bit we, input int ws, input int wrr, input int wm);
        logic [SB_W-1:0] e;
        hwag_start       = start;
        acnt             = a[23:0];
        cam_phase        = c;
        bus.wr_en        = we;
        bus.wr_set       = ws[12:0];
        bus.wr_reset     = wrr[12:0];
        bus.wr_max_dwell = wm[23:0];
        @(posedge clk);
        model_step(start, a, c, we, ws, wrr, wm);
        exp_q.push_back({(m_mode == M_ON), m_pending, m_tmo, m_angle[12:0]});
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq("out", out, e[15]);
        check_eq("pending", bus.pending, e[14]);
        check_eq("dwell_tmo", bus.dwell_tmo, e[13]);
        check_eq("cyc_angle", cyc_angle, e[12:0]);
    endtask

    task automatic tick();
        step(st, cur_a, cam, 0, 0, 0, 0);
    endtask

    task automatic goto(input int a);
        cur_a = a;
        tick();
    endtask

    task automatic write_cfg(input int s, input int r, input int m);
        step(st, cur_a, cam, 1, s, r, m);
    endtask

    task automatic ramp_watch(input int from, input int to);
        bit prev;
        rise_a = -1;
        fall_a = -1;
        prev = out;
        goto(from);
        forever begin
            if (out && !prev && rise_a < 0) rise_a = cur_a;
            if (!out && prev && fall_a < 0) fall_a = cur_a;
            prev = out;
            if (cur_a == to) break;
            goto((cur_a + 1) % ANG_PER_REV);
        end
    endtask

    task automatic resync(input int s, input int r, input int m, input bit c);
        st = 0;
        tick();
        write_cfg(s, r, m);
        tick();
        tick();
        cam = c;
        st = 1;
        tick();
        tick();
    endtask

    task automatic wrap_cycle();
        goto(3839); goto(0); goto(3839); goto(0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_hi, r;
        hwag_start = 0; acnt = '0; cam_phase = 0;
        bus.wr_en = 0; bus.wr_set = '0; bus.wr_reset = '0; bus.wr_max_dwell = '0;
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out", out, 0);
        check_eq("rst_cyc", cyc_angle, 0);
        check_eq("rst_pending", bus.pending, 0);
        check_eq("rst_tmo", bus.dwell_tmo, 0);
        check_eq("rst_state", state, OFF);
        rst = 0;

        // cam seed and phase toggle
        cur_a = 100;
        tick(); tick();
        cam = 1; st = 1;
        tick();
        check_eq("seed_cyc", cyc_angle, 3940);
        goto(3839);
        check_eq("rev2_end", cyc_angle, 7679);
        goto(0);
        check_eq("wrap_zero", cyc_angle, 0);
        goto(1);
        check_eq("phase0", cyc_angle, 1);

        // normal pulse, then repeated next cycle
        resync(1000, 1128, 0, 0);
        ramp_watch(cur_a, 995);
        ramp_watch(996, 1200);
        check_eq("pulse_rise", rise_a, 1001);
        check_eq("pulse_fall", fall_a, 1129);
        wrap_cycle();
        ramp_watch(990, 1050);
        check_eq("repeat_rise", rise_a, 1001);

        // double buffer: write mid-pulse
        write_cfg(2000, 2100, 0);
        check_eq("db_pending", bus.pending, 1);
        ramp_watch(1051, 1140);
        check_eq("db_old_fall", fall_a, 1129);
        check_eq("db_still_pend", bus.pending, 1);
        wrap_cycle();
        tick();
        check_eq("db_applied", bus.pending, 0);
        ramp_watch(990, 2110);
        check_eq("db_new_rise", rise_a, 2001);
        check_eq("db_new_fall", fall_a, 2101);

        // dwell guard, one acnt step per 10 clk
        resync(1000, 1128, 50, 0);
        goto(990);
        n_hi = 0;
        for (int a = 991; a <= 1140; a++) begin
            cur_a = a;
            repeat (10) begin
                tick();
                if (out) n_hi++;
            end
        end
        check_eq("dwell_len", n_hi, 50);
        check_eq("dwell_tmo", bus.dwell_tmo, 1);
        wrap_cycle();
        ramp_watch(990, 1010);
        check_eq("rearm_rise", rise_a, 1001);
        check_eq("tmo_sticky", bus.dwell_tmo, 1);

        // sync loss mid-pulse
        write_cfg(1000, 1128, 0);
        st = 0;
        tick();
        check_eq("loss_out", out, 0);
        check_eq("loss_state", state, OFF);
        tick();
        check_eq("loss_applied", bus.pending, 0);
        cam = 0; st = 1;
        tick();
        ramp_watch(1011, 1140);
        check_eq("no_resume", rise_a, -1);
        wrap_cycle();
        ramp_watch(990, 1010);
        check_eq("resync_rise", rise_a, 1001);

        // set == reset, and a jump across set
        resync(500, 500, 0, 0);
        ramp_watch(480, 520);
        check_eq("eq_no_rise", rise_a, -1);
        resync(1000, 1128, 0, 0);
        ramp_watch(980, 990);
        ramp_watch(1010, 1140);
        check_eq("skip_no_rise", rise_a, -1);

        // out-of-range angle clamps
        step(st, 5000, cam, 0, 0, 0, 0);
        check_eq("clamp", cyc_angle, 3839);
        cur_a = 3839;

        // random walk
        for (int i = 0; i < 8000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 8) begin
                if (st) st = 0;
                else begin
                    cam = $urandom_range(0, 1);
                    st = 1;
                end
                tick();
            end else if (r < 20) begin
                int ws, wrr, wm;
                ws  = (m_angle + $urandom_range(10, 600)) % ANG_PER_CYCLE;
                wrr = ($urandom_range(0, 9) == 0) ? ws : (ws + $urandom_range(1, 300)) % ANG_PER_CYCLE;
                wm  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 120);
                write_cfg(ws, wrr, wm);
            end else if (r < 30) begin
                goto($urandom_range(0, ANG_PER_REV - 1));
            end else if (r < 35) begin
                step(st, $urandom_range(ANG_PER_REV, 24'hFFFFFF), cam, 0, 0, 0, 0);
                cur_a = ANG_PER_REV - 1;
            end else if (r < 200) begin
                tick();
            end else begin
                goto((cur_a + 1) % ANG_PER_REV);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
